// File: rtl/button_events.sv
// Debounced button levels to single-cycle press events with typematic repeat.
// One independent IDLE/HOLD/REPEAT machine and counter per button.
module button_fsm #(
  parameter int CNT_W         = 27,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic ev,
  output logic rpt,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, nState;
  logic [CNT_W-1:0] cnt, nCnt;
  logic nEv, nRpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ev    <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= nState;
      cnt   <= nCnt;
      ev    <= nEv;
      rpt   <= nRpt;
    end
  end

  // Release wins over a terminal count in the same cycle.
  always_comb begin
    nState = state;
    nCnt   = cnt;
    nEv    = 1'b0;
    nRpt   = 1'b0;
    if (!btn) begin
      nState = IDLE;
      nCnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nState = HOLD;
          nCnt   = '0;
          nEv    = 1'b1;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            nState = REPEAT;
            nCnt   = '0;
            nEv    = 1'b1;
            nRpt   = 1'b1;
          end else begin
            nCnt = cnt + ONE;
          end
        end
        REPEAT: begin
          if (cnt == RPT_LAST) begin
            nCnt = '0;
            nEv  = 1'b1;
            nRpt = 1'b1;
          end else begin
            nCnt = cnt + ONE;
          end
        end
        default: begin
          nState = IDLE;
          nCnt   = '0;
        end
      endcase
    end
  end

  assign held = (state != IDLE);

endmodule

module button_events #(
  parameter int CNT_W         = 27,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnR_D,
  input  logic       btnL_D,
  input  logic       btnD_D,
  input  logic       btnU_D,
  output logic       evR,
  output logic       evL,
  output logic       evD,
  output logic       evU,
  output logic [3:0] ev_rpt,
  output logic [3:0] held
);

  logic [3:0] btnVec;
  logic [3:0] evVec;

  assign btnVec = {btnU_D, btnD_D, btnL_D, btnR_D};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_fsm #(
      .CNT_W        (CNT_W),
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_fsm (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btnVec[i]),
      .ev   (evVec[i]),
      .rpt  (ev_rpt[i]),
      .held (held[i])
    );
  end

  assign evR = evVec[0];
  assign evL = evVec[1];
  assign evD = evVec[2];
  assign evU = evVec[3];

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: HOLD_DELAY=10 with
// REPEAT_PERIOD=4 (dut) and REPEAT_PERIOD=1 (dut1).
module tb_button_events;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn = 4'hf;

  logic evR, evL, evD, evU;
  logic [3:0] rpt, hld;
  logic evR1, evL1, evD1, evU1;
  logic [3:0] rpt1, hld1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  button_events #(
    .CNT_W(8), .HOLD_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btnR_D(btn[0]), .btnL_D(btn[1]),
    .btnD_D(btn[2]), .btnU_D(btn[3]),
    .evR(evR), .evL(evL), .evD(evD), .evU(evU),
    .ev_rpt(rpt), .held(hld)
  );

  button_events #(
    .CNT_W(8), .HOLD_DELAY(10), .REPEAT_PERIOD(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .btnR_D(btn[0]), .btnL_D(btn[1]),
    .btnD_D(btn[2]), .btnU_D(btn[3]),
    .evR(evR1), .evL(evL1), .evD(evD1), .evU(evU1),
    .ev_rpt(rpt1), .held(hld1)
  );

  // {held, ev_rpt, evU, evD, evL, evR}
  wire [11:0] o0 = {hld, rpt, evU, evD, evL, evR};
  wire [11:0] o1 = {hld1, rpt1, evU1, evD1, evL1, evR1};

  task automatic chk(input string tag,
                     input logic [11:0] obs,
                     input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Hold button b for n sampled cycles on dut and check every
  // cycle against hand-written pulse/repeat masks.
  task automatic holdChk(input string tag, input int b,
                         input int n,
                         input logic [31:0] pm,
                         input logic [31:0] rm);
    logic [3:0] oh;
    logic [11:0] e;
    oh = 4'b0001 << b;
    btn[b] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = {oh, rm[k] ? oh : 4'h0, pm[k] ? oh : 4'h0};
      chk($sformatf("%s_c%0d", tag, k), o0, e);
    end
    btn[b] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_rel", tag), o0, 12'h000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] e;
    logic [31:0] m1;

    // reset held low with every button pressed
    @(negedge clk);
    @(negedge clk);
    chk("rst_dut", o0, 12'h000);
    chk("rst_dut1", o1, 12'h000);

    // reset release with R high: press pulse next cycle
    btn = 4'b0001;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_press", o0, 12'h101);
    chk("rst_press1", o1, 12'h101);
    @(negedge clk);
    chk("rst_hold", o0, 12'h100);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("rst_rel", o0, 12'h000);
    @(negedge clk);

    // short press, no repeat
    holdChk("shortL", 1, 5, 32'h1, 32'h0);
    @(negedge clk);

    // long hold: pulses at 0,10,14,18,22,26
    holdChk("longU", 3, 30, 32'h0444_4401, 32'h0444_4400);
    @(negedge clk);

    // release exactly on the first repeat edge
    holdChk("relD", 2, 10, 32'h1, 32'h0);
    @(negedge clk);

    // R and L together; R released after 5 cycles
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    @(negedge clk);
    chk("simul_c0", o0, 12'h303);
    for (int k = 1; k < 16; k++) begin
      if (k == 5) btn[0] = 1'b0;
      @(negedge clk);
      e[11:8] = (k < 5) ? 4'b0011 : 4'b0010;
      e[7:4] = (k == 10 || k == 14) ? 4'b0010 : 4'b0000;
      e[3:0] = e[7:4];
      chk($sformatf("simul_c%0d", k), o0, e);
    end
    btn[1] = 1'b0;
    @(negedge clk);
    chk("simul_rel", o0, 12'h000);
    @(negedge clk);

    // hold R 20 cycles on both configs
    m1 = 32'h000f_fc01;
    btn[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      e = {4'b0001,
           (k == 10 || k == 14 || k == 18) ? 4'b0001 : 4'b0000,
           (k == 0 || k == 10 || k == 14 || k == 18)
             ? 4'b0001 : 4'b0000};
      chk($sformatf("rptR_c%0d", k), o0, e);
      e = {4'b0001, (m1[k] && k != 0) ? 4'b0001 : 4'b0000,
           m1[k] ? 4'b0001 : 4'b0000};
      chk($sformatf("rpt1R_c%0d", k), o1, e);
    end

    // async reset between edges, no clock needed
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dut", o0, 12'h000);
    chk("arst_dut1", o1, 12'h000);
    @(negedge clk);
    chk("arst_stay", o0, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_press", o0, 12'h101);
    chk("arst_press1", o1, 12'h101);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("arst_rel", o0, 12'h000);
    chk("arst_rel1", o1, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
